// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline register bundle.
// master: decode side (drives id_*, wb_*, flush, ex_hold; observes stall and ex_*).
// slave : the ID/EX stage itself.
interface id_ex_stage_if #(
    parameter int unsigned DW = 32
);
    // decode slot
    logic          id_valid;
    logic [4:0]    id_rs;
    logic [4:0]    id_rt;
    logic [4:0]    id_rd;
    logic          id_uses_rt;
    logic [DW-1:0] id_Adat;
    logic [DW-1:0] id_Bdat;
    logic [DW-1:0] id_imm;
    logic          id_RegWrite;
    logic          id_MemRead;
    logic          id_MemWrite;
    logic          id_MemtoReg;
    logic          id_ALUSrc;
    logic          id_RegDst;
    logic [3:0]    id_ALUop;
    // write-back port
    logic          wb_RegWrite;
    logic [4:0]    wb_regW;
    logic [DW-1:0] wb_Wdat;
    // pipeline control
    logic          flush;
    logic          ex_hold;
    logic          stall;
    // execute slot
    logic          ex_valid;
    logic          ex_RegWrite;
    logic          ex_MemRead;
    logic          ex_MemWrite;
    logic          ex_MemtoReg;
    logic          ex_ALUSrc;
    logic [3:0]    ex_ALUop;
    logic [4:0]    ex_rs;
    logic [4:0]    ex_rt;
    logic [4:0]    ex_dst;
    logic [DW-1:0] ex_A;
    logic [DW-1:0] ex_B;
    logic [DW-1:0] ex_imm;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_Adat, id_Bdat, id_imm,
               id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc, id_RegDst,
               id_ALUop, wb_RegWrite, wb_regW, wb_Wdat, flush, ex_hold,
        input  stall, ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg,
               ex_ALUSrc, ex_ALUop, ex_rs, ex_rt, ex_dst, ex_A, ex_B, ex_imm
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_Adat, id_Bdat, id_imm,
               id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc, id_RegDst,
               id_ALUop, wb_RegWrite, wb_regW, wb_Wdat, flush, ex_hold,
        output stall, ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg,
               ex_ALUSrc, ex_ALUop, ex_rs, ex_rt, ex_dst, ex_A, ex_B, ex_imm
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and write-back bypass.
// Ports: clk, resetn (asynchronous, active-high), bus (id_ex_stage_if.slave).
// stall is combinational (hazard | ex_hold); every ex_* output is a flop.
module id_ex_stage #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    id_ex_stage_if.slave  bus
);
    localparam int unsigned RW  = 5;
    localparam int unsigned OPW = 4;

    logic           ex_valid_q,    ex_valid_d;
    logic           ex_regwrite_q, ex_regwrite_d;
    logic           ex_memread_q,  ex_memread_d;
    logic           ex_memwrite_q, ex_memwrite_d;
    logic           ex_memtoreg_q, ex_memtoreg_d;
    logic           ex_alusrc_q,   ex_alusrc_d;
    logic [OPW-1:0] ex_aluop_q,    ex_aluop_d;
    logic [RW-1:0]  ex_rs_q,       ex_rs_d;
    logic [RW-1:0]  ex_rt_q,       ex_rt_d;
    logic [RW-1:0]  ex_dst_q,      ex_dst_d;
    logic [DW-1:0]  ex_a_q,        ex_a_d;
    logic [DW-1:0]  ex_b_q,        ex_b_d;
    logic [DW-1:0]  ex_imm_q,      ex_imm_d;

    logic           hazard_c;
    logic [RW-1:0]  id_dst_c;
    logic [DW-1:0]  fwd_a_c;
    logic [DW-1:0]  fwd_b_c;

    // Load-use hazard; ex_dst is already 0 for non-writing instructions, so r0 never matches.
    always_comb begin
        hazard_c = ex_valid_q && ex_memread_q && (ex_dst_q != '0) && bus.id_valid &&
                   ((ex_dst_q == bus.id_rs) || (bus.id_uses_rt && (ex_dst_q == bus.id_rt)));
    end

    assign bus.stall = hazard_c | bus.ex_hold;

    // Destination resolution and write-back bypass (register file read is stale this cycle).
    always_comb begin
        id_dst_c = '0;
        if (bus.id_RegWrite) begin
            id_dst_c = bus.id_RegDst ? bus.id_rd : bus.id_rt;
        end
        fwd_a_c = bus.id_Adat;
        fwd_b_c = bus.id_Bdat;
        if (bus.wb_RegWrite && (bus.wb_regW != '0) && (bus.wb_regW == bus.id_rs)) begin
            fwd_a_c = bus.wb_Wdat;
        end
        if (bus.wb_RegWrite && (bus.wb_regW != '0) && (bus.wb_regW == bus.id_rt)) begin
            fwd_b_c = bus.wb_Wdat;
        end
    end

    // Next-state: flush > ex_hold > hazard bubble > capture.
    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_regwrite_d = ex_regwrite_q;
        ex_memread_d  = ex_memread_q;
        ex_memwrite_d = ex_memwrite_q;
        ex_memtoreg_d = ex_memtoreg_q;
        ex_alusrc_d   = ex_alusrc_q;
        ex_aluop_d    = ex_aluop_q;
        ex_rs_d       = ex_rs_q;
        ex_rt_d       = ex_rt_q;
        ex_dst_d      = ex_dst_q;
        ex_a_d        = ex_a_q;
        ex_b_d        = ex_b_q;
        ex_imm_d      = ex_imm_q;

        if (bus.flush || (!bus.ex_hold && hazard_c)) begin
            // Kill or bubble: operand fields are left as they are.
            ex_valid_d    = 1'b0;
            ex_regwrite_d = 1'b0;
            ex_memread_d  = 1'b0;
            ex_memwrite_d = 1'b0;
            ex_memtoreg_d = 1'b0;
            ex_alusrc_d   = 1'b0;
            ex_aluop_d    = '0;
            ex_dst_d      = '0;
        end else if (!bus.ex_hold) begin
            ex_valid_d    = bus.id_valid;
            ex_regwrite_d = bus.id_valid & bus.id_RegWrite;
            ex_memread_d  = bus.id_valid & bus.id_MemRead;
            ex_memwrite_d = bus.id_valid & bus.id_MemWrite;
            ex_memtoreg_d = bus.id_valid & bus.id_MemtoReg;
            ex_alusrc_d   = bus.id_valid & bus.id_ALUSrc;
            ex_aluop_d    = bus.id_valid ? bus.id_ALUop : '0;
            ex_dst_d      = bus.id_valid ? id_dst_c : '0;
            ex_rs_d       = bus.id_rs;
            ex_rt_d       = bus.id_rt;
            ex_a_d        = fwd_a_c;
            ex_b_d        = fwd_b_c;
            ex_imm_d      = bus.id_imm;
        end
    end

    // EX slot register.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            ex_valid_q    <= 1'b0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
            ex_memwrite_q <= 1'b0;
            ex_memtoreg_q <= 1'b0;
            ex_alusrc_q   <= 1'b0;
            ex_aluop_q    <= '0;
            ex_rs_q       <= '0;
            ex_rt_q       <= '0;
            ex_dst_q      <= '0;
            ex_a_q        <= '0;
            ex_b_q        <= '0;
            ex_imm_q      <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_regwrite_q <= ex_regwrite_d;
            ex_memread_q  <= ex_memread_d;
            ex_memwrite_q <= ex_memwrite_d;
            ex_memtoreg_q <= ex_memtoreg_d;
            ex_alusrc_q   <= ex_alusrc_d;
            ex_aluop_q    <= ex_aluop_d;
            ex_rs_q       <= ex_rs_d;
            ex_rt_q       <= ex_rt_d;
            ex_dst_q      <= ex_dst_d;
            ex_a_q        <= ex_a_d;
            ex_b_q        <= ex_b_d;
            ex_imm_q      <= ex_imm_d;
        end
    end

    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_RegWrite = ex_regwrite_q;
    assign bus.ex_MemRead  = ex_memread_q;
    assign bus.ex_MemWrite = ex_memwrite_q;
    assign bus.ex_MemtoReg = ex_memtoreg_q;
    assign bus.ex_ALUSrc   = ex_alusrc_q;
    assign bus.ex_ALUop    = ex_aluop_q;
    assign bus.ex_rs       = ex_rs_q;
    assign bus.ex_rt       = ex_rt_q;
    assign bus.ex_dst      = ex_dst_q;
    assign bus.ex_A        = ex_a_q;
    assign bus.ex_B        = ex_b_q;
    assign bus.ex_imm      = ex_imm_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then randomized traffic against a reference model.
module tb_id_ex_stage;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    id_ex_stage_if #(.DW(DW)) bus ();
    id_ex_stage #(.DW(DW)) dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

    int errors = 0;
    int checks = 0;

    // Reference view of the EX slot.
    logic          m_valid, m_rw, m_mr, m_mw, m_m2r, m_as;
    logic [3:0]    m_op;
    logic [4:0]    m_rs, m_rt, m_dst;
    logic [DW-1:0] m_a, m_b, m_imm;
    bit            m_ops;   // operand fields hold a known value

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        {m_valid, m_rw, m_mr, m_mw, m_m2r, m_as} = '0;
        m_op = '0; m_rs = '0; m_rt = '0; m_dst = '0;
        m_a = '0; m_b = '0; m_imm = '0;
        m_ops = 1'b1;
    endtask

    task automatic model_kill();
        {m_valid, m_rw, m_mr, m_mw, m_m2r, m_as} = '0;
        m_op = '0; m_dst = '0;
        m_ops = 1'b0;
    endtask

    function automatic logic model_hazard();
        return m_valid && m_mr && (m_dst != 5'd0) && bus.id_valid &&
               ((m_dst == bus.id_rs) || (bus.id_uses_rt && (m_dst == bus.id_rt)));
    endfunction

    // Value a source register really holds this cycle, including the write landing now.
    function automatic logic [DW-1:0] reg_value(input logic [4:0] r, input logic [DW-1:0] rf);
        return (bus.wb_RegWrite && (bus.wb_regW != 5'd0) && (bus.wb_regW == r)) ? bus.wb_Wdat : rf;
    endfunction

    task automatic model_edge();
        if (resetn) model_reset();
        else if (bus.flush) model_kill();
        else if (bus.ex_hold) begin
        end
        else if (model_hazard()) model_kill();
        else if (!bus.id_valid) model_kill();
        else begin
            m_valid = 1'b1;
            m_rw  = bus.id_RegWrite; m_mr = bus.id_MemRead; m_mw = bus.id_MemWrite;
            m_m2r = bus.id_MemtoReg; m_as = bus.id_ALUSrc;  m_op = bus.id_ALUop;
            m_dst = !bus.id_RegWrite ? 5'd0 : (bus.id_RegDst ? bus.id_rd : bus.id_rt);
            m_rs  = bus.id_rs; m_rt = bus.id_rt;
            m_a   = reg_value(bus.id_rs, bus.id_Adat);
            m_b   = reg_value(bus.id_rt, bus.id_Bdat);
            m_imm = bus.id_imm;
            m_ops = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ":valid"},  DW'(bus.ex_valid),    DW'(m_valid));
        check({tag, ":rw"},     DW'(bus.ex_RegWrite), DW'(m_rw));
        check({tag, ":mr"},     DW'(bus.ex_MemRead),  DW'(m_mr));
        check({tag, ":mw"},     DW'(bus.ex_MemWrite), DW'(m_mw));
        check({tag, ":m2r"},    DW'(bus.ex_MemtoReg), DW'(m_m2r));
        check({tag, ":alusrc"}, DW'(bus.ex_ALUSrc),   DW'(m_as));
        check({tag, ":aluop"},  DW'(bus.ex_ALUop),    DW'(m_op));
        check({tag, ":dst"},    DW'(bus.ex_dst),      DW'(m_dst));
        if (m_ops) begin
            check({tag, ":rs"},  DW'(bus.ex_rs), DW'(m_rs));
            check({tag, ":rt"},  DW'(bus.ex_rt), DW'(m_rt));
            check({tag, ":A"},   bus.ex_A,   m_a);
            check({tag, ":B"},   bus.ex_B,   m_b);
            check({tag, ":imm"}, bus.ex_imm, m_imm);
        end
    endtask

    // Let inputs settle, check stall, clock once, check the EX slot.
    task automatic step(input string tag);
        #1;
        check({tag, ":stall"}, DW'(bus.stall), DW'(model_hazard() || bus.ex_hold));
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic uses_rt,
                          input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] imm,
                          input logic rw, input logic mr, input logic mw, input logic m2r,
                          input logic as, input logic rdst, input logic [3:0] op);
        bus.id_valid = v; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
        bus.id_uses_rt = uses_rt; bus.id_Adat = a; bus.id_Bdat = b; bus.id_imm = imm;
        bus.id_RegWrite = rw; bus.id_MemRead = mr; bus.id_MemWrite = mw;
        bus.id_MemtoReg = m2r; bus.id_ALUSrc = as; bus.id_RegDst = rdst; bus.id_ALUop = op;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] r, input logic [DW-1:0] d);
        bus.wb_RegWrite = we; bus.wb_regW = r; bus.wb_Wdat = d;
    endtask

    task automatic load_word(input logic [4:0] dst);
        set_id(1'b1, 5'd1, dst, 5'd0, 1'b0, 32'h100, 32'h0, 32'h4,
               1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    endtask

    initial begin
        resetn = 1'b1;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        set_wb(1'b0, 5'd0, '0);
        bus.flush = 1'b0;
        bus.ex_hold = 1'b0;
        model_reset();

        // Reset state, and stall follows ex_hold while in reset
        #12;
        check_all("reset");
        check("reset:stall", DW'(bus.stall), DW'(1'b0));
        bus.ex_hold = 1'b1; #1;
        check("reset:stall_hold", DW'(bus.stall), DW'(1'b1));
        bus.ex_hold = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b0;

        // Basic capture on the first edge after reset release
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 32'h11, 32'h22, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
        step("cap");
        check("cap:dst3", DW'(bus.ex_dst), DW'(5'd3));
        check("cap:A", bus.ex_A, 32'h11);
        check("cap:B", bus.ex_B, 32'h22);
        check("cap:stall0", DW'(bus.stall), DW'(1'b0));

        // Load-use: one bubble, then the dependent instruction enters
        load_word(5'd5);
        step("lw5");
        set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 32'h50, 32'h60, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
        #1;
        check("lu:stall1", DW'(bus.stall), DW'(1'b1));
        step("lu_bubble");
        check("lu:bubble_valid", DW'(bus.ex_valid), DW'(1'b0));
        check("lu:stall_after", DW'(bus.stall), DW'(1'b0));
        step("lu_capture");
        check("lu:captured", DW'(bus.ex_valid), DW'(1'b1));
        check("lu:captured_rs", DW'(bus.ex_rs), DW'(5'd5));

        // Load to r0 never creates a hazard
        set_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 32'h100, 32'h0, 32'h4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        step("lw0");
        set_id(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
        #1;
        check("r0:stall0", DW'(bus.stall), DW'(1'b0));
        step("r0_use");
        check("r0:no_bubble", DW'(bus.ex_valid), DW'(1'b1));

        // Write-back bypass into both operands; r0 is never bypassed
        set_wb(1'b1, 5'd7, 32'hDEAD);
        set_id(1'b1, 5'd7, 5'd7, 5'd9, 1'b1, 32'h1, 32'h2, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4);
        step("byp7");
        check("byp:A", bus.ex_A, 32'hDEAD);
        check("byp:B", bus.ex_B, 32'hDEAD);
        set_wb(1'b1, 5'd0, 32'hDEAD);
        set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 32'h1, 32'h2, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4);
        step("byp0");
        check("byp0:A", bus.ex_A, 32'h1);
        set_wb(1'b0, 5'd0, '0);

        // Hazard and bypass on the same operand: the bubble wins
        load_word(5'd4);
        step("lw4");
        set_wb(1'b1, 5'd4, 32'hBEEF);
        set_id(1'b1, 5'd4, 5'd0, 5'd9, 1'b0, 32'h1, 32'h2, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4);
        step("hz_byp");
        check("hz_byp:bubble", DW'(bus.ex_valid), DW'(1'b0));
        set_wb(1'b0, 5'd0, '0);

        // Flush beats hold and hazard
        load_word(5'd5);
        step("lw5b");
        set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 32'h50, 32'h60, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
        bus.flush = 1'b1; bus.ex_hold = 1'b1;
        step("flush");
        check("flush:valid", DW'(bus.ex_valid), DW'(1'b0));
        check("flush:mr", DW'(bus.ex_MemRead), DW'(1'b0));
        bus.flush = 1'b0; bus.ex_hold = 1'b0;

        // Hold for three cycles: EX frozen, stall high throughout
        set_id(1'b1, 5'd2, 5'd3, 5'd4, 1'b1, 32'h55, 32'h66, 32'h7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd6);
        step("pre_hold");
        bus.ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 5'(i + 10), 5'(i + 11), 5'(i + 12), 1'b1, DW'(i), DW'(i + 1), DW'(i + 2),
                   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'(i));
            step("hold");
            check("hold:stall", DW'(bus.stall), DW'(1'b1));
            check("hold:A", bus.ex_A, 32'h55);
            check("hold:valid", DW'(bus.ex_valid), DW'(1'b1));
        end
        bus.ex_hold = 1'b0;

        // Async reset between edges while EX is valid
        set_id(1'b1, 5'd2, 5'd3, 5'd4, 1'b1, 32'h77, 32'h88, 32'h9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
        step("pre_rst");
        #2; resetn = 1'b1; #1;
        model_reset();
        check_all("async_rst");
        check("async_rst:valid", DW'(bus.ex_valid), DW'(1'b0));
        resetn = 1'b0;
        step("post_rst_cap");
        check("post_rst:valid", DW'(bus.ex_valid), DW'(1'b1));

        // Reset during a pending load-use bubble leaves no stall behind
        load_word(5'd6);
        step("lw6");
        set_id(1'b1, 5'd6, 5'd1, 5'd2, 1'b1, 32'h1, 32'h2, 32'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
        #1;
        check("pre_rst_bubble:stall", DW'(bus.stall), DW'(1'b1));
        resetn = 1'b1; #1;
        model_reset();
        check("rst_bubble:stall", DW'(bus.stall), DW'(1'b0));
        resetn = 1'b0;
        step("rst_bubble_cap");

        // Randomized traffic with occasional mid-cycle resets
        for (int n = 0; n < 400; n++) begin
            set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 1'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
                   1'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 4'($urandom));
            set_wb(1'($urandom), 5'($urandom_range(0, 7)), DW'($urandom));
            bus.flush   = 1'($urandom_range(0, 9) == 0);
            bus.ex_hold = 1'($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 49) == 0) begin
                resetn = 1'b1; #1;
                model_reset();
                check_all("rnd_rst");
                resetn = 1'b0;
            end
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
